// File: rtl/captura_trama_ps2.sv
`default_nettype none
// ============================================================================
//  Module   : captura_trama_ps2
//  Purpose  : Arms on START_CODE, collects N_DIGITS decimal make-codes from
//             the PS/2 receiver byte stream, and publishes BCD digits plus a
//             saturated binary value. Filters break/extended prefixes,
//             restarts on START_CODE, aborts on bad codes or inter-byte
//             timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module captura_trama_ps2 #(
  parameter int          N_DIGITS    = 2,
  parameter logic [7:0]  START_CODE  = 8'h5A,
  parameter int          VAL_W       = 7,
  parameter int          TIMEOUT_CYC = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            dato,
  input  logic                  tick,
  output logic [4*N_DIGITS-1:0] digits_bcd,
  output logic [VAL_W-1:0]      value,
  output logic                  value_sat,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int EXT_W = VAL_W + 5;

  localparam logic [EXT_W-1:0] VAL_MAX    = {{5{1'b0}}, {VAL_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);
  // Counter value one cycle before the abort: the abort is registered on the
  // edge where the count would reach TIMEOUT_CYC-1.
  localparam logic [TO_W-1:0]  TO_LAST    = (TIMEOUT_CYC >= 2) ? TO_W'(TIMEOUT_CYC - 2) : '0;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state;
  logic             skip;
  logic [CNT_W-1:0] count;
  logic [VAL_W-1:0] acc;
  logic             sat;
  logic [BCD_W-1:0] shadow;
  logic [TO_W-1:0]  to_cnt;

  logic             is_digit;
  logic [3:0]       digit;
  logic [EXT_W-1:0] acc_ext;
  logic [VAL_W-1:0] acc_next;
  logic             sat_next;
  logic [BCD_W-1:0] shadow_next;
  logic             timeout_hit;

  // Make-code to decimal digit lookup
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (dato)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // Next accumulator/shadow values if the current byte is accepted as a digit
  always_comb begin
    acc_ext          = ({{5{1'b0}}, acc} * EXT_W'(10)) + EXT_W'(digit);
    acc_next         = acc_ext[VAL_W-1:0];
    sat_next         = sat;
    if (sat || (acc_ext > VAL_MAX)) begin
      acc_next = {VAL_W{1'b1}};
      sat_next = 1'b1;
    end
    shadow_next      = shadow << 4;
    shadow_next[3:0] = digit;
  end

  // A zero TIMEOUT_CYC disables the abort entirely
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYC == 1)
      timeout_hit = 1'b1;
    else if (TIMEOUT_CYC >= 2)
      timeout_hit = (to_cnt == TO_LAST);
  end

  assign busy = (state == ARMED);

  // Capture FSM: prefix filter first, then IDLE/ARMED handling and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      skip        <= 1'b0;
      count       <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      shadow      <= '0;
      to_cnt      <= '0;
      digits_bcd  <= '0;
      value       <= '0;
      value_sat   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (tick) begin
        to_cnt <= '0;
        if (skip) begin
          // Byte following a prefix is discarded; a repeated F0 keeps skipping
          if (dato != CODE_BREAK)
            skip <= 1'b0;
        end else if ((dato == CODE_EXT) || (dato == CODE_BREAK)) begin
          skip <= 1'b1;
        end else if (state == IDLE) begin
          if (dato == START_CODE) begin
            state  <= ARMED;
            count  <= '0;
            acc    <= '0;
            sat    <= 1'b0;
            shadow <= '0;
          end
        end else begin
          if (dato == START_CODE) begin
            count  <= '0;
            acc    <= '0;
            sat    <= 1'b0;
            shadow <= '0;
          end else if (is_digit) begin
            shadow <= shadow_next;
            acc    <= acc_next;
            sat    <= sat_next;
            count  <= count + 1'b1;
            if (count == LAST_DIGIT) begin
              digits_bcd  <= shadow_next;
              value       <= acc_next;
              value_sat   <= sat_next;
              frame_valid <= 1'b1;
              state       <= IDLE;
              count       <= '0;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
            count     <= '0;
          end
        end
      end else if (state == ARMED) begin
        if (timeout_hit) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          count     <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire
